uart_rx: RTL

//   Serial receive stage feeding the uart top: takes the asynchronous rx line,

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_baud_gen.sv | 32 +++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, oversample constants and a
// counter-width helper. Used by both the receive and transmit paths.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;

  // Tick index at the middle of the start bit (checked on the 8th tick).
  localparam int START_MID = OVERSAMPLE / 2 - 1;

  // Minimum counter width able to hold the values 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Free-running oversample tick generator: one-clock tick every DIVISOR clocks.
module uart_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int DIVISOR = 326
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = cnt_width(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  // Count 0..DIVISOR-1 and wrap; tick is asserted on the terminal count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 deserialiser with a one-entry holding
// register (valid/ready), framing-error and overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DIVISOR = 326
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  input  logic            data_ready,
  output logic [DBIT-1:0] dout,
  output logic            data_valid,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun
);

  localparam logic [3:0] S_START_LAST = 4'(START_MID);
  localparam logic [3:0] S_DATA_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_STOP_LAST  = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST       = 3'(DBIT - 1);

  logic            w_tick;

  logic            r_rx_meta;
  logic            r_rx_s;

  uart_state_e     r_state, w_state_nxt;
  logic [3:0]      r_s, w_s_nxt;
  logic [2:0]      r_n, w_n_nxt;
  logic [DBIT-1:0] r_shift, w_shift_nxt;
  logic            w_deliver;
  logic            w_stop_bad;
  logic            w_accept;

  logic [DBIT-1:0] r_dout;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;

  uart_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud_gen (
    .clock(clock),
    .reset(reset),
    .tick (w_tick)
  );

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state, oversample count, bit index and shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: start detect in IDLE is immediate, all else waits for a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_s == S_START_LAST) begin
            // Line must still be low mid-bit, otherwise it was a glitch.
            if (!r_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s == S_DATA_LAST) begin
            w_shift_nxt = {r_rx_s, r_shift[DBIT-1:1]};
            w_s_nxt     = '0;
            if (r_n == N_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_state_nxt = IDLE;
            if (r_rx_s) begin
              w_deliver = 1'b1;
            end else begin
              w_stop_bad = 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A finished byte can be stored when the register is empty or being drained.
  assign w_accept = w_deliver && (!r_valid || data_ready);

  // Holding register with valid/ready handshake plus error pulse flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_deliver && r_valid && !data_ready;
      if (w_accept) begin
        r_dout  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign data_valid = r_valid;
  assign busy       = (r_state != IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
